// File: rtl/axi_lite_timeout_guard.sv
// AXI4-Lite per-port watchdog: forwards one read and one write at a time and
// answers SLVERR locally once the guarded slave has missed its deadline.
package axi_lite_timeout_guard_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } ax_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } w_chan_t;

    typedef struct packed {
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } resp_t;
endpackage

module axi_lite_timeout_guard #(
    parameter int unsigned TimeoutCycles = 1024,
    parameter type         axi_req_t     = axi_lite_timeout_guard_pkg::req_t,
    parameter type         axi_resp_t    = axi_lite_timeout_guard_pkg::resp_t,
    parameter int unsigned CntWidth      = $clog2(TimeoutCycles + 1)
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_resp_o,
    output axi_req_t  mst_req_o,
    input  axi_resp_t mst_resp_i,
    input  logic      clr_isolate_i,
    output logic      isolated_o,
    output logic [7:0] timeout_cnt_o
);
    localparam logic [1:0]          RespSlvErr = 2'b10;
    localparam logic [CntWidth-1:0] TimerLast  = CntWidth'(TimeoutCycles - 1);

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_LOCAL} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP, R_LOCAL} r_state_e;

    w_state_e            w_state;
    r_state_e            r_state;
    logic                aw_done, w_done, ar_done;
    logic [CntWidth-1:0] w_timer, r_timer;

    logic w_fwd, r_fwd, w_last, r_last;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic w_timeout, r_timeout;
    logic [8:0] to_sum;

    assign w_last = (w_timer == TimerLast);
    assign r_last = (r_timer == TimerLast);
    // In the final REQ cycle no completion is possible, so forwarding stops at once.
    assign w_fwd  = (w_state == W_REQ) && !w_last;
    assign r_fwd  = (r_state == R_REQ) && !r_last;

    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.aw_valid = w_fwd && !aw_done && slv_req_i.aw_valid;
        mst_req_o.w_valid  = w_fwd && !w_done && slv_req_i.w_valid;
        mst_req_o.b_ready  = (w_state == W_RESP) ? slv_req_i.b_ready
                                                 : (isolated_o && (w_state != W_REQ));
        mst_req_o.ar_valid = r_fwd && !ar_done && slv_req_i.ar_valid;
        mst_req_o.r_ready  = (r_state == R_RESP) ? slv_req_i.r_ready
                                                 : (isolated_o && (r_state != R_REQ));

        slv_resp_o          = '0;
        slv_resp_o.aw_ready = (w_fwd && !aw_done && mst_resp_i.aw_ready)
                            || ((w_state == W_LOCAL) && !aw_done);
        slv_resp_o.w_ready  = (w_fwd && !w_done && mst_resp_i.w_ready)
                            || ((w_state == W_LOCAL) && !w_done);
        if (w_state == W_RESP) begin
            slv_resp_o.b       = mst_resp_i.b;
            slv_resp_o.b_valid = mst_resp_i.b_valid;
        end else if (w_state == W_LOCAL) begin
            slv_resp_o.b.resp  = RespSlvErr;
            slv_resp_o.b_valid = aw_done && w_done;
        end

        slv_resp_o.ar_ready = (r_fwd && !ar_done && mst_resp_i.ar_ready)
                            || ((r_state == R_LOCAL) && !ar_done);
        if (r_state == R_RESP) begin
            slv_resp_o.r       = mst_resp_i.r;
            slv_resp_o.r_valid = mst_resp_i.r_valid;
        end else if (r_state == R_LOCAL) begin
            slv_resp_o.r.resp  = RespSlvErr;
            slv_resp_o.r_valid = ar_done;
        end
    end

    assign aw_hs = slv_req_i.aw_valid && slv_resp_o.aw_ready;
    assign w_hs  = slv_req_i.w_valid && slv_resp_o.w_ready;
    assign b_hs  = slv_resp_o.b_valid && slv_req_i.b_ready;
    assign ar_hs = slv_req_i.ar_valid && slv_resp_o.ar_ready;
    assign r_hs  = slv_resp_o.r_valid && slv_req_i.r_ready;

    assign w_timeout = w_last && ((w_state == W_REQ) || ((w_state == W_RESP) && !b_hs));
    assign r_timeout = r_last && ((r_state == R_REQ) || ((r_state == R_RESP) && !r_hs));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state <= W_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            w_timer <= '0;
        end else begin
            unique case (w_state)
                W_IDLE: if (slv_req_i.aw_valid) begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    w_timer <= '0;
                    w_state <= isolated_o ? W_LOCAL : W_REQ;
                end
                W_REQ: begin
                    w_timer <= w_timer + CntWidth'(1);
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if (w_timeout)                                     w_state <= W_LOCAL;
                    else if ((aw_done || aw_hs) && (w_done || w_hs)) w_state <= W_RESP;
                end
                W_RESP: begin
                    w_timer <= w_timer + CntWidth'(1);
                    if (w_timeout) begin
                        w_state <= W_LOCAL;
                    end else if (b_hs) begin
                        w_state <= W_IDLE;
                        w_timer <= '0;
                    end
                end
                W_LOCAL: begin
                    w_timer <= '0;
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if (b_hs)  w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= R_IDLE;
            ar_done <= 1'b0;
            r_timer <= '0;
        end else begin
            unique case (r_state)
                R_IDLE: if (slv_req_i.ar_valid) begin
                    ar_done <= 1'b0;
                    r_timer <= '0;
                    r_state <= isolated_o ? R_LOCAL : R_REQ;
                end
                R_REQ: begin
                    r_timer <= r_timer + CntWidth'(1);
                    if (ar_hs) ar_done <= 1'b1;
                    if (r_timeout)  r_state <= R_LOCAL;
                    else if (ar_hs) r_state <= R_RESP;
                end
                R_RESP: begin
                    r_timer <= r_timer + CntWidth'(1);
                    if (r_timeout) begin
                        r_state <= R_LOCAL;
                    end else if (r_hs) begin
                        r_state <= R_IDLE;
                        r_timer <= '0;
                    end
                end
                R_LOCAL: begin
                    r_timer <= '0;
                    if (ar_hs) ar_done <= 1'b1;
                    if (r_hs)  r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign to_sum = {1'b0, timeout_cnt_o} + {8'b0, w_timeout} + {8'b0, r_timeout};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            isolated_o    <= 1'b0;
            timeout_cnt_o <= '0;
        end else begin
            if (w_timeout || r_timeout)
                isolated_o <= 1'b1;
            else if (clr_isolate_i && (w_state == W_IDLE) && (r_state == R_IDLE))
                isolated_o <= 1'b0;
            timeout_cnt_o <= to_sum[8] ? 8'hFF : to_sum[7:0];
        end
    end
endmodule

// File: tb/tb_axi_lite_timeout_guard.sv
// Directed bench for axi_lite_timeout_guard with TimeoutCycles=16; the bench
// plays both the xbar master port and the guarded slave.
module tb_axi_lite_timeout_guard;
    import axi_lite_timeout_guard_pkg::*;

    localparam int OKAY   = 0;
    localparam int SLVERR = 2;

    logic       clk_i = 1'b0;
    logic       rst_i;
    req_t       slv_req;
    resp_t      slv_resp;
    req_t       mst_req;
    resp_t      mst_resp;
    logic       clr_isolate;
    logic       isolated;
    logic [7:0] timeout_cnt;

    int n_asserts = 0;
    int n_fail    = 0;

    axi_lite_timeout_guard #(
        .TimeoutCycles (16),
        .axi_req_t     (req_t),
        .axi_resp_t    (resp_t)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .slv_req_i     (slv_req),
        .slv_resp_o    (slv_resp),
        .mst_req_o     (mst_req),
        .mst_resp_i    (mst_resp),
        .clr_isolate_i (clr_isolate),
        .isolated_o    (isolated),
        .timeout_cnt_o (timeout_cnt)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves isolation, launches a write and a read that the slave accepts but
    // never answers, and returns in the first cycle both paths sit in *_LOCAL.
    task automatic start_pair();
        clr_isolate = 1'b1;
        tick();
        clr_isolate         = 1'b0;
        slv_req.aw_valid    = 1'b1;
        slv_req.w_valid     = 1'b1;
        slv_req.ar_valid    = 1'b1;
        slv_req.b_ready     = 1'b1;
        slv_req.r_ready     = 1'b1;
        mst_resp.aw_ready   = 1'b1;
        mst_resp.w_ready    = 1'b1;
        mst_resp.ar_ready   = 1'b1;
        mst_resp.b_valid    = 1'b0;
        mst_resp.r_valid    = 1'b0;
        tick();
        tick();
        slv_req.aw_valid = 1'b0;
        slv_req.w_valid  = 1'b0;
        slv_req.ar_valid = 1'b0;
        repeat (15) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_i       = 1'b1;
        clr_isolate = 1'b0;
        slv_req     = '0;
        mst_resp    = '0;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        check("rst_slv_aw_ready", 32'(slv_resp.aw_ready), 0);
        check("rst_slv_b_valid",  32'(slv_resp.b_valid),  0);
        check("rst_slv_r_valid",  32'(slv_resp.r_valid),  0);
        check("rst_mst_b_ready",  32'(mst_req.b_ready),   0);
        check("rst_isolated",     32'(isolated),          0);
        check("rst_cnt",          32'(timeout_cnt),       0);

        // Normal write, slave answers OKAY a few cycles after accepting.
        slv_req.aw.addr   = 32'h40;
        slv_req.aw_valid  = 1'b1;
        slv_req.w.data    = 32'h1234_5678;
        slv_req.w.strb    = 4'hF;
        slv_req.w_valid   = 1'b1;
        slv_req.b_ready   = 1'b1;
        mst_resp.aw_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;
        #1;
        check("t1_idle_mst_aw_valid", 32'(mst_req.aw_valid),   0);
        check("t1_idle_slv_aw_ready", 32'(slv_resp.aw_ready),  0);
        tick();
        check("t1_fwd_aw_valid", 32'(mst_req.aw_valid),  1);
        check("t1_fwd_aw_addr",  mst_req.aw.addr,        32'h40);
        check("t1_fwd_w_data",   mst_req.w.data,         32'h1234_5678);
        check("t1_slv_aw_ready", 32'(slv_resp.aw_ready), 1);
        tick();
        slv_req.aw_valid = 1'b0;
        slv_req.w_valid  = 1'b0;
        #1;
        check("t1_resp_aw_valid", 32'(mst_req.aw_valid), 0);
        check("t1_resp_b_ready",  32'(mst_req.b_ready),  1);
        repeat (4) begin
            tick();
            check("t1_no_b_yet", 32'(slv_resp.b_valid), 0);
        end
        mst_resp.b_valid = 1'b1;
        mst_resp.b.resp  = 2'(OKAY);
        #1;
        check("t1_b_valid", 32'(slv_resp.b_valid), 1);
        check("t1_b_resp",  32'(slv_resp.b.resp),  OKAY);
        tick();
        mst_resp.b_valid = 1'b0;
        #1;
        check("t1_b_done",   32'(slv_resp.b_valid), 0);
        check("t1_isolated", 32'(isolated),         0);
        check("t1_cnt",      32'(timeout_cnt),      0);

        // Hung write: slave accepts AW/W but never answers.
        slv_req.aw.addr  = 32'h48;
        slv_req.aw_valid = 1'b1;
        slv_req.w_valid  = 1'b1;
        #1;
        tick();
        check("t2_mst_aw_valid", 32'(mst_req.aw_valid), 1);
        tick();
        slv_req.aw_valid = 1'b0;
        slv_req.w_valid  = 1'b0;
        repeat (14) begin
            tick();
            check("t2_no_b_before_timeout", 32'(slv_resp.b_valid), 0);
        end
        check("t2_not_isolated_yet", 32'(isolated), 0);
        tick();
        check("t2_b_valid",      32'(slv_resp.b_valid), 1);
        check("t2_b_slverr",     32'(slv_resp.b.resp),  SLVERR);
        check("t2_isolated",     32'(isolated),         1);
        check("t2_cnt",          32'(timeout_cnt),      1);
        check("t2_mst_aw_valid", 32'(mst_req.aw_valid), 0);
        tick();
        check("t2_b_done", 32'(slv_resp.b_valid), 0);

        // Read while isolated is answered locally; clear is ignored in R_LOCAL.
        slv_req.ar.addr   = 32'h80;
        slv_req.ar_valid  = 1'b1;
        slv_req.r_ready   = 1'b1;
        mst_resp.ar_ready = 1'b1;
        mst_resp.r.data   = 32'hDEAD_BEEF;
        #1;
        check("t3_idle_mst_ar_valid", 32'(mst_req.ar_valid),  0);
        check("t3_idle_slv_ar_ready", 32'(slv_resp.ar_ready), 0);
        tick();
        check("t3_local_ar_ready",    32'(slv_resp.ar_ready), 1);
        check("t3_local_mst_ar_valid", 32'(mst_req.ar_valid), 0);
        check("t3_local_no_r_yet",    32'(slv_resp.r_valid),  0);
        tick();
        slv_req.ar_valid = 1'b0;
        clr_isolate      = 1'b1;
        #1;
        check("t3_r_valid",  32'(slv_resp.r_valid), 1);
        check("t3_r_slverr", 32'(slv_resp.r.resp),  SLVERR);
        check("t3_r_data",   slv_resp.r.data,       32'h0);
        tick();
        clr_isolate = 1'b0;
        #1;
        check("t5_clr_ignored", 32'(isolated),         1);
        check("t3_r_done",      32'(slv_resp.r_valid), 0);
        mst_resp.b_valid = 1'b1;
        mst_resp.b.resp  = 2'(OKAY);
        clr_isolate      = 1'b1;
        #1;
        check("t3_stray_b_ready",     32'(mst_req.b_ready),   1);
        check("t3_stray_not_forward", 32'(slv_resp.b_valid),  0);
        tick();
        clr_isolate      = 1'b0;
        mst_resp.b_valid = 1'b0;
        #1;
        check("t5_clr_idle",      32'(isolated),        0);
        check("t5_cnt_kept",      32'(timeout_cnt),     1);
        check("t5_b_ready_off",   32'(mst_req.b_ready), 0);

        // After clearing, a write is forwarded again.
        slv_req.aw.addr  = 32'h44;
        slv_req.aw_valid = 1'b1;
        slv_req.w_valid  = 1'b1;
        #1;
        tick();
        check("t5_fwd_aw_valid", 32'(mst_req.aw_valid),  1);
        check("t5_fwd_aw_addr",  mst_req.aw.addr,        32'h44);
        check("t5_slv_aw_ready", 32'(slv_resp.aw_ready), 1);
        tick();
        slv_req.aw_valid = 1'b0;
        slv_req.w_valid  = 1'b0;
        mst_resp.b_valid = 1'b1;
        #1;
        check("t5_b_valid", 32'(slv_resp.b_valid), 1);
        check("t5_b_okay",  32'(slv_resp.b.resp),  OKAY);
        tick();
        mst_resp.b_valid = 1'b0;
        #1;

        // Read completing in the very last allowed cycle is a success.
        slv_req.ar.addr  = 32'h84;
        slv_req.ar_valid = 1'b1;
        #1;
        tick();
        check("t4_fwd_ar_valid", 32'(mst_req.ar_valid), 1);
        check("t4_fwd_ar_addr",  mst_req.ar.addr,        32'h84);
        tick();
        slv_req.ar_valid = 1'b0;
        repeat (14) begin
            tick();
            check("t4_no_r_yet", 32'(slv_resp.r_valid), 0);
        end
        mst_resp.r_valid = 1'b1;
        mst_resp.r.data  = 32'hCAFE_0084;
        mst_resp.r.resp  = 2'(OKAY);
        #1;
        check("t4_r_valid", 32'(slv_resp.r_valid), 1);
        check("t4_r_data",  slv_resp.r.data,       32'hCAFE_0084);
        check("t4_r_okay",  32'(slv_resp.r.resp),  OKAY);
        tick();
        mst_resp.r_valid = 1'b0;
        #1;
        check("t4_isolated", 32'(isolated),         0);
        check("t4_cnt",      32'(timeout_cnt),      1);
        check("t4_r_done",   32'(slv_resp.r_valid), 0);

        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        check("rst2_cnt", 32'(timeout_cnt), 0);

        // Simultaneous write and read timeouts count twice.
        start_pair();
        check("t6_cnt_two",     32'(timeout_cnt),       2);
        check("t6_isolated",    32'(isolated),          1);
        check("t6_b_slverr",    32'(slv_resp.b.resp),   SLVERR);
        check("t6_b_valid",     32'(slv_resp.b_valid),  1);
        check("t6_r_valid",     32'(slv_resp.r_valid),  1);
        check("t6_r_slverr",    32'(slv_resp.r.resp),   SLVERR);
        check("t6_mst_ar_off",  32'(mst_req.ar_valid),  0);
        check("t6_mst_r_ready", 32'(mst_req.r_ready),   1);
        tick();

        repeat (126) begin
            start_pair();
            tick();
        end
        check("sat_cnt_254", 32'(timeout_cnt), 254);
        start_pair();
        check("sat_cnt_255", 32'(timeout_cnt), 255);
        tick();

        // Reset while a write and a read are being forwarded.
        clr_isolate = 1'b1;
        tick();
        clr_isolate      = 1'b0;
        slv_req.aw_valid = 1'b1;
        slv_req.w_valid  = 1'b1;
        slv_req.ar_valid = 1'b1;
        mst_resp.aw_ready = 1'b0;
        mst_resp.w_ready  = 1'b0;
        mst_resp.ar_ready = 1'b0;
        #1;
        tick();
        check("t6r_fwd_aw_valid", 32'(mst_req.aw_valid), 1);
        check("t6r_fwd_ar_valid", 32'(mst_req.ar_valid), 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        check("t6r_aw_valid",  32'(mst_req.aw_valid),  0);
        check("t6r_w_valid",   32'(mst_req.w_valid),   0);
        check("t6r_ar_valid",  32'(mst_req.ar_valid),  0);
        check("t6r_b_valid",   32'(slv_resp.b_valid),  0);
        check("t6r_r_valid",   32'(slv_resp.r_valid),  0);
        check("t6r_cnt",       32'(timeout_cnt),       0);
        check("t6r_isolated",  32'(isolated),          0);
        slv_req = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
